// File: rtl/sa_job_scheduler_if.sv
// Job/array/result signal bundle between the scheduler, its two requesters,
// the shared systolic array and the result consumer.
interface sa_job_scheduler_if #(
   parameter int N = 4,
   parameter int W = 8
);
   localparam int MW = N * N * W;

   logic [1:0]    i_req_valid;
   logic [1:0]    o_req_ready;
   logic [MW-1:0] i_req0_a;
   logic [MW-1:0] i_req0_b;
   logic [MW-1:0] i_req1_a;
   logic [MW-1:0] i_req1_b;
   logic [MW-1:0] o_sa_a;
   logic [MW-1:0] o_sa_b;
   logic          o_sa_valid;
   logic [MW-1:0] i_sa_c;
   logic          i_sa_valid;
   logic          o_res_valid;
   logic          i_res_ready;
   logic          o_res_id;
   logic [MW-1:0] o_res_c;
   logic          o_busy;
   logic          o_timeout;
   logic          o_timeout_sticky;

   modport slave (
      input  i_req_valid, i_req0_a, i_req0_b, i_req1_a, i_req1_b,
      input  i_sa_c, i_sa_valid, i_res_ready,
      output o_req_ready, o_sa_a, o_sa_b, o_sa_valid,
      output o_res_valid, o_res_id, o_res_c,
      output o_busy, o_timeout, o_timeout_sticky
   );

   modport master (
      output i_req_valid, i_req0_a, i_req0_b, i_req1_a, i_req1_b,
      output i_sa_c, i_sa_valid, i_res_ready,
      input  o_req_ready, o_sa_a, o_sa_b, o_sa_valid,
      input  o_res_valid, o_res_id, o_res_c,
      input  o_busy, o_timeout, o_timeout_sticky
   );
endinterface

// File: rtl/sa_job_scheduler.sv
// Round-robin scheduler of two requesters onto one shared systolic array,
// with a WAIT-state watchdog that drops jobs the array never answers.
module sa_job_scheduler #(
   parameter int N       = 4,
   parameter int W       = 8,
   parameter int TIMEOUT = 64
) (
   input  logic              i_clk,
   input  logic              i_arst,
   sa_job_scheduler_if.slave bus
);
   localparam int MW = N * N * W;
   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t        state_q, state_d;
   logic          last_q, last_d;
   logic          id_q, id_d;
   logic [MW-1:0] sa_a_q, sa_a_d;
   logic [MW-1:0] sa_b_q, sa_b_d;
   logic [MW-1:0] res_c_q, res_c_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sa_valid_q, sa_valid_d;
   logic          res_valid_q, res_valid_d;
   logic          busy_q, busy_d;
   logic          timeout_q, timeout_d;
   logic          sticky_q, sticky_d;
   logic [1:0]    gnt;
   logic [1:0]    req_ready;

   // On contention the requester that did not win last time is granted.
   always_comb begin
      gnt = bus.i_req_valid;
      if (&bus.i_req_valid) begin
         gnt = last_q ? 2'b01 : 2'b10;
      end
      req_ready = (state_q == S_IDLE) ? gnt : 2'b00;
   end

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      id_d        = id_q;
      sa_a_d      = sa_a_q;
      sa_b_d      = sa_b_q;
      res_c_d     = res_c_q;
      cnt_d       = cnt_q;
      sa_valid_d  = 1'b0;
      res_valid_d = res_valid_q;
      busy_d      = busy_q;
      timeout_d   = 1'b0;
      sticky_d    = sticky_q;
      unique case (state_q)
         S_IDLE: begin
            if (|req_ready) begin
               id_d       = req_ready[1];
               last_d     = req_ready[1];
               sa_a_d     = req_ready[1] ? bus.i_req1_a : bus.i_req0_a;
               sa_b_d     = req_ready[1] ? bus.i_req1_b : bus.i_req0_b;
               sa_valid_d = 1'b1;
               busy_d     = 1'b1;
               state_d    = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // A result arriving on the last allowed cycle still beats the watchdog.
            if (bus.i_sa_valid) begin
               res_c_d     = bus.i_sa_c;
               res_valid_d = 1'b1;
               state_d     = S_RESP;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               timeout_d = 1'b1;
               sticky_d  = 1'b1;
               busy_d    = 1'b0;
               state_d   = S_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_RESP: begin
            if (bus.i_res_ready) begin
               res_valid_d = 1'b0;
               busy_d      = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         state_q     <= S_IDLE;
         last_q      <= 1'b1;
         id_q        <= 1'b0;
         sa_a_q      <= '0;
         sa_b_q      <= '0;
         res_c_q     <= '0;
         cnt_q       <= '0;
         sa_valid_q  <= 1'b0;
         res_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         timeout_q   <= 1'b0;
         sticky_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         id_q        <= id_d;
         sa_a_q      <= sa_a_d;
         sa_b_q      <= sa_b_d;
         res_c_q     <= res_c_d;
         cnt_q       <= cnt_d;
         sa_valid_q  <= sa_valid_d;
         res_valid_q <= res_valid_d;
         busy_q      <= busy_d;
         timeout_q   <= timeout_d;
         sticky_q    <= sticky_d;
      end
   end

   assign bus.o_req_ready      = req_ready;
   assign bus.o_sa_a           = sa_a_q;
   assign bus.o_sa_b           = sa_b_q;
   assign bus.o_sa_valid       = sa_valid_q;
   assign bus.o_res_valid      = res_valid_q;
   assign bus.o_res_id         = id_q;
   assign bus.o_res_c          = res_c_q;
   assign bus.o_busy           = busy_q;
   assign bus.o_timeout        = timeout_q;
   assign bus.o_timeout_sticky = sticky_q;
endmodule

// File: tb/tb_sa_job_scheduler.sv
// Directed bench for sa_job_scheduler (N=4, W=8, TIMEOUT=8); the bench plays
// both requesters, the systolic array and the result consumer.
module tb_sa_job_scheduler;
   localparam int N  = 4;
   localparam int W  = 8;
   localparam int MW = N * N * W;

   logic i_clk;
   logic i_arst;
   int   n_chk;
   int   n_fail;

   logic [MW-1:0] a0, b0, a1, b1;

   sa_job_scheduler_if #(.N(N), .W(W)) bus ();

   sa_job_scheduler #(.N(N), .W(W), .TIMEOUT(8)) dut (
      .i_clk  (i_clk),
      .i_arst (i_arst),
      .bus    (bus)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check_eq(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_req_ready"}, bus.o_req_ready, '0);
      check_eq({tag, "_sa_a"}, bus.o_sa_a, '0);
      check_eq({tag, "_sa_b"}, bus.o_sa_b, '0);
      check_eq({tag, "_sa_valid"}, bus.o_sa_valid, '0);
      check_eq({tag, "_res_valid"}, bus.o_res_valid, '0);
      check_eq({tag, "_res_id"}, bus.o_res_id, '0);
      check_eq({tag, "_res_c"}, bus.o_res_c, '0);
      check_eq({tag, "_busy"}, bus.o_busy, '0);
      check_eq({tag, "_timeout"}, bus.o_timeout, '0);
      check_eq({tag, "_sticky"}, bus.o_timeout_sticky, '0);
   endtask

   // Starts in IDLE just after an edge; the array answers in WAIT cycle lat,
   // the consumer stalls for hold cycles before accepting.
   task automatic run_job(input logic [1:0] vld, input logic exp_id, input int lat,
                          input int hold, input logic [MW-1:0] res);
      bus.i_req_valid = vld;
      #1;
      check_eq("grant", bus.o_req_ready, exp_id ? 2'b10 : 2'b01);
      step();
      check_eq("issue_sa_valid", bus.o_sa_valid, 1'b1);
      check_eq("issue_sa_a", bus.o_sa_a, exp_id ? a1 : a0);
      check_eq("issue_sa_b", bus.o_sa_b, exp_id ? b1 : b0);
      check_eq("issue_busy", bus.o_busy, 1'b1);
      check_eq("issue_req_ready", bus.o_req_ready, 2'b00);
      step();
      for (int i = 1; i < lat; i++) begin
         check_eq("wait_sa_valid", bus.o_sa_valid, 1'b0);
         check_eq("wait_res_valid", bus.o_res_valid, 1'b0);
         step();
      end
      bus.i_sa_valid = 1'b1;
      bus.i_sa_c     = res;
      step();
      bus.i_sa_valid = 1'b0;
      bus.i_sa_c     = ~res;
      check_eq("resp_valid", bus.o_res_valid, 1'b1);
      check_eq("resp_id", bus.o_res_id, exp_id);
      check_eq("resp_c", bus.o_res_c, res);
      check_eq("resp_no_timeout", bus.o_timeout, 1'b0);
      for (int i = 0; i < hold; i++) begin
         step();
         check_eq("hold_valid", bus.o_res_valid, 1'b1);
         check_eq("hold_id", bus.o_res_id, exp_id);
         check_eq("hold_c", bus.o_res_c, res);
         check_eq("hold_req_ready", bus.o_req_ready, 2'b00);
      end
      bus.i_res_ready = 1'b1;
      step();
      bus.i_res_ready = 1'b0;
      check_eq("done_res_valid", bus.o_res_valid, 1'b0);
      check_eq("done_busy", bus.o_busy, 1'b0);
      bus.i_req_valid = 2'b00;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      a0 = '0;
      for (int i = 0; i < N; i++) a0[(i*N+i)*W +: W] = 8'h10;
      b0 = 128'h1014_0408_1408_100C_F408_0C10_100C_F014;
      a1 = 128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F11;
      b1 = 128'hA5A5_5A5A_1234_5678_9ABC_DEF0_0F1E_2D3C;
      bus.i_req_valid = 2'b00;
      bus.i_req0_a    = a0;
      bus.i_req0_b    = b0;
      bus.i_req1_a    = a1;
      bus.i_req1_b    = b1;
      bus.i_sa_c      = '0;
      bus.i_sa_valid  = 1'b0;
      bus.i_res_ready = 1'b0;
      i_arst          = 1'b1;
      #3;
      check_all_zero("reset");
      @(negedge i_clk);
      i_arst = 1'b0;
      step();

      // Single job: identity times b returns b.
      run_job(2'b01, 1'b0, 1, 0, b0);

      // Contention from reset, both requesters held valid.
      i_arst = 1'b1;
      #1;
      i_arst = 1'b0;
      step();
      run_job(2'b11, 1'b0, 2, 0, 128'h1111);
      run_job(2'b11, 1'b1, 3, 0, 128'h2222);
      run_job(2'b11, 1'b0, 1, 0, 128'h3333);
      run_job(2'b11, 1'b1, 4, 0, 128'h4444);

      // Consumer back-pressure for 10 cycles.
      run_job(2'b11, 1'b0, 2, 10, 128'hDEAD_BEEF_0000_CAFE);

      // Array never answers: watchdog fires after the 8th WAIT cycle.
      bus.i_req_valid = 2'b01;
      step();
      bus.i_req_valid = 2'b00;
      step();
      for (int i = 1; i <= 8; i++) begin
         check_eq("to_wait_timeout", bus.o_timeout, 1'b0);
         check_eq("to_wait_busy", bus.o_busy, 1'b1);
         step();
      end
      check_eq("to_pulse", bus.o_timeout, 1'b1);
      check_eq("to_sticky", bus.o_timeout_sticky, 1'b1);
      check_eq("to_busy", bus.o_busy, 1'b0);
      check_eq("to_res_valid", bus.o_res_valid, 1'b0);
      step();
      check_eq("to_pulse_end", bus.o_timeout, 1'b0);
      check_eq("to_sticky_held", bus.o_timeout_sticky, 1'b1);
      check_eq("to_res_valid2", bus.o_res_valid, 1'b0);
      run_job(2'b10, 1'b1, 2, 0, 128'h5555);

      // Result on the same cycle the counter reaches TIMEOUT-1.
      run_job(2'b01, 1'b0, 8, 0, 128'h6666_7777);

      // Reset 3 cycles into WAIT; a late array valid must be ignored.
      bus.i_req_valid = 2'b01;
      step();
      bus.i_req_valid = 2'b00;
      step();
      step();
      step();
      step();
      i_arst = 1'b1;
      #1;
      check_all_zero("arst");
      i_arst         = 1'b0;
      bus.i_sa_valid = 1'b1;
      bus.i_sa_c     = 128'h9999;
      step();
      bus.i_sa_valid = 1'b0;
      check_eq("late_res_valid", bus.o_res_valid, 1'b0);
      check_eq("late_busy", bus.o_busy, 1'b0);
      check_eq("late_res_c", bus.o_res_c, '0);
      step();
      check_eq("late_res_valid2", bus.o_res_valid, 1'b0);
      bus.i_req_valid = 2'b11;
      #1;
      check_eq("post_reset_grant", bus.o_req_ready, 2'b01);
      bus.i_req_valid = 2'b00;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
